// File: rtl/mnist_img_loader.sv
// Host-side MNIST frame loader.
// Packs a byte stream into the image bus, launches, returns the digit.
module mnist_img_loader #(
   parameter int IMG_SIZE = 784,
   parameter int TIMEOUT  = 8192
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [7:0]              s_data,
   input  logic                    s_last,
   output logic [IMG_SIZE*8-1:0]   img_data,
   output logic                    start,
   input  logic                    done,
   input  logic [3:0]              pred_digit,
   output logic                    r_valid,
   input  logic                    r_ready,
   output logic [7:0]              r_data,
   output logic                    busy,
   output logic                    frame_err
);

   typedef enum logic [1:0] {
      S_RECV,
      S_LAUNCH,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [9:0]  CNT_LAST = 10'(IMG_SIZE - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t                  state_q, state_d;
   logic [9:0]              cnt_q, cnt_d;
   logic [IMG_SIZE*8-1:0]   img_q, img_d;
   logic                    armed_q, armed_d;
   logic [15:0]             tmo_q, tmo_d;
   logic [15:0]             tmo_nxt;
   logic                    start_q, start_d;
   logic                    ferr_q, ferr_d;
   logic [7:0]              rdata_q, rdata_d;

   assign s_ready   = (state_q == S_RECV);
   assign busy      = (state_q != S_RECV);
   assign r_valid   = (state_q == S_RESP);
   assign img_data  = img_q;
   assign start     = start_q;
   assign frame_err = ferr_q;
   assign r_data    = rdata_q;
   assign tmo_nxt   = tmo_q + 16'd1;

   // Next-state: frame assembly, launch, armed done capture, timeout
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      img_d   = img_q;
      armed_d = armed_q;
      tmo_d   = tmo_q;
      start_d = 1'b0;
      ferr_d  = 1'b0;
      rdata_d = rdata_q;
      unique case (state_q)
         S_RECV: begin
            if (s_valid) begin
               img_d[{cnt_q, 3'b000} +: 8] = s_data;
               if (cnt_q == CNT_LAST) begin
                  cnt_d = 10'd0;
                  if (s_last) begin
                     state_d = S_LAUNCH;
                     start_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else if (s_last) begin
                  cnt_d  = 10'd0;
                  ferr_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
         end
         S_LAUNCH: begin
            armed_d = 1'b0;
            tmo_d   = 16'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (armed_q && done) begin
               rdata_d = {4'h0, pred_digit};
               state_d = S_RESP;
            end else if (tmo_nxt == TMO_LAST) begin
               rdata_d = 8'hE0;
               tmo_d   = tmo_nxt;
               state_d = S_RESP;
            end else begin
               tmo_d = tmo_nxt;
               if (!done) begin
                  armed_d = 1'b1;
               end
            end
         end
         S_RESP: begin
            if (r_ready) begin
               state_d = S_RECV;
            end
         end
      endcase
   end

   // State and registered outputs, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_RECV;
         cnt_q   <= 10'd0;
         img_q   <= '0;
         armed_q <= 1'b0;
         tmo_q   <= 16'd0;
         start_q <= 1'b0;
         ferr_q  <= 1'b0;
         rdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         img_q   <= img_d;
         armed_q <= armed_d;
         tmo_q   <= tmo_d;
         start_q <= start_d;
         ferr_q  <= ferr_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mnist_img_loader.sv
// Bench for mnist_img_loader.
// Main instance uses default TIMEOUT; a second instance uses TIMEOUT=64.
module tb_mnist_img_loader;

   localparam int N = 784;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en_t, rst_m, rst_t;
   assign rst_m = rst & ~en_t;
   assign rst_t = rst & en_t;

   logic       s_valid, s_last, done, r_ready;
   logic [7:0] s_data;
   logic [3:0] pred;

   logic             s_ready, start, r_valid, busy, ferr;
   logic [7:0]       r_data;
   logic [N*8-1:0]   img;
   logic             t_s_ready, t_start, t_r_valid, t_busy, t_ferr;
   logic [7:0]       t_r_data;
   logic [N*8-1:0]   t_img;

   mnist_img_loader dut (
      .clk(clk), .rst(rst_m),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .img_data(img), .start(start), .done(done), .pred_digit(pred),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
      .busy(busy), .frame_err(ferr)
   );

   mnist_img_loader #(.TIMEOUT(64)) dut_t (
      .clk(clk), .rst(rst_t),
      .s_valid(s_valid), .s_ready(t_s_ready), .s_data(s_data), .s_last(s_last),
      .img_data(t_img), .start(t_start), .done(done), .pred_digit(pred),
      .r_valid(t_r_valid), .r_ready(r_ready), .r_data(t_r_data),
      .busy(t_busy), .frame_err(t_ferr)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: expected pixel store and write position
   logic [7:0] exp_img [N];
   int mcnt;
   int start_cnt = 0;
   int ferr_cnt  = 0;

   always @(posedge clk) begin
      if (start === 1'b1) start_cnt++;
      if (ferr === 1'b1) ferr_cnt++;
   end

   function automatic int img_diffs(input logic [N*8-1:0] v);
      int n = 0;
      for (int k = 0; k < N; k++)
         if (v[k*8 +: 8] !== exp_img[k]) n++;
      return n;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) exp_img[k] = 8'h00;
      mcnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      @(negedge clk);
      exp_img[mcnt] = d;
      if (last || mcnt == N - 1) mcnt = 0;
      else mcnt++;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'($urandom);
   endtask

   task automatic send_frame(input int n, input int last_at, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom % 4) == 0) begin
            s_valid = 1'b0;
            s_last  = 1'($urandom % 2);
            @(negedge clk);
            s_last  = 1'b0;
         end
         send_byte(8'($urandom), i == last_at);
      end
   endtask

   task automatic wait_resp(input int bound, output int cyc);
      cyc = 0;
      while (r_valid !== 1'b1 && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic handshake();
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
      done    = 1'b0;
   endtask

   task automatic test_reset();
      int sc;
      #3;
      checks++;
      if ({s_ready, start, busy, ferr, r_valid, r_data} !== 13'b1_0000_0000_0000) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b",
                  {s_ready, start, busy, ferr, r_valid, r_data}, 13'b1_0000_0000_0000);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send_frame(50, -1, 0);
      checks++;
      if (img_diffs(img) !== 0) begin
         errors++;
         $display("FAIL partial_img diffs=%0d exp=0", img_diffs(img));
      end
      #2 rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if (img !== '0 || {s_ready, start, busy, ferr, r_valid, r_data} !== 13'b1_0000_0000_0000) begin
         errors++;
         $display("FAIL async_reset_mid_frame got=%b img_nz=%0d exp=%b",
                  {s_ready, start, busy, ferr, r_valid, r_data}, img != '0, 13'b1_0000_0000_0000);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_release got=%b exp=1", s_ready);
      end
      send_frame(N, N - 1, 0);
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_in_wait got=%b exp=1", busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || r_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_mid_wait busy=%b r_valid=%b exp=0,0", busy, r_valid);
      end
      model_reset();
      sc = start_cnt;
      @(negedge clk);
      rst  = 1'b1;
      done = 1'b1;
      pred = 4'd5;
      repeat (20) @(negedge clk);
      checks++;
      if (r_valid !== 1'b0 || start_cnt !== sc) begin
         errors++;
         $display("FAIL aborted_frame_silent r_valid=%b starts=%0d exp=0,%0d",
                  r_valid, start_cnt, sc);
      end
      done = 1'b0;
   endtask

   task automatic test_nominal();
      int stalls = 0;
      int sc = start_cnt;
      for (int k = 0; k < N; k++) begin
         if (s_ready !== 1'b1) stalls++;
         send_byte(k[7:0], k == N - 1);
      end
      checks++;
      if (stalls !== 0) begin
         errors++;
         $display("FAIL nominal_throughput stalls=%0d exp=0", stalls);
      end
      checks++;
      if (start !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL nominal_start start=%b busy=%b exp=1,1", start, busy);
      end
      checks++;
      if (img[7:0] !== 8'h00 || img[N*8-1 -: 8] !== 8'h0F || img_diffs(img) !== 0) begin
         errors++;
         $display("FAIL nominal_img first=%h last=%h diffs=%0d exp=00,0f,0",
                  img[7:0], img[N*8-1 -: 8], img_diffs(img));
      end
      @(negedge clk);
      checks++;
      if (start !== 1'b0) begin
         errors++;
         $display("FAIL nominal_start_width got=%b exp=0", start);
      end
      repeat (899) @(negedge clk);
      checks++;
      if (r_valid !== 1'b0) begin
         errors++;
         $display("FAIL nominal_early_resp got=%b exp=0", r_valid);
      end
      done = 1'b1;
      pred = 4'd6;
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1 || r_data !== 8'h06 || start_cnt !== sc + 1) begin
         errors++;
         $display("FAIL nominal_resp r_valid=%b r_data=%h starts=%0d exp=1,06,%0d",
                  r_valid, r_data, start_cnt - sc, 1);
      end
      handshake();
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b0 || r_valid !== 1'b0) begin
         errors++;
         $display("FAIL nominal_return s_ready=%b busy=%b r_valid=%b exp=1,0,0",
                  s_ready, busy, r_valid);
      end
   endtask

   task automatic test_early_last();
      int sc = start_cnt;
      int fc = ferr_cnt;
      int c;
      send_frame(101, 100, 0);
      checks++;
      if (ferr !== 1'b1) begin
         errors++;
         $display("FAIL early_ferr got=%b exp=1", ferr);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (start_cnt !== sc || ferr_cnt !== fc + 1 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL early_discard starts=%0d ferrs=%0d s_ready=%b exp=0,1,1",
                  start_cnt - sc, ferr_cnt - fc, s_ready);
      end
      send_frame(N, N - 1, 0);
      checks++;
      if (img_diffs(img) !== 0 || start !== 1'b1) begin
         errors++;
         $display("FAIL early_next_frame diffs=%0d start=%b exp=0,1", img_diffs(img), start);
      end
      repeat ($urandom_range(50, 10)) @(negedge clk);
      done = 1'b1;
      pred = 4'd3;
      wait_resp(5, c);
      checks++;
      if (r_valid !== 1'b1 || r_data !== 8'h03) begin
         errors++;
         $display("FAIL early_result r_valid=%b r_data=%h exp=1,03", r_valid, r_data);
      end
      handshake();
   endtask

   task automatic test_missing_last();
      int sc = start_cnt;
      int fc = ferr_cnt;
      int c;
      logic [7:0] b;
      logic [3:0] dg;
      send_frame(N, -1, 0);
      checks++;
      if (ferr !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL missing_ferr ferr=%b s_ready=%b busy=%b exp=1,1,0", ferr, s_ready, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (start_cnt !== sc || ferr_cnt !== fc + 1) begin
         errors++;
         $display("FAIL missing_counts starts=%0d ferrs=%0d exp=0,1",
                  start_cnt - sc, ferr_cnt - fc);
      end
      b = 8'($urandom);
      send_byte(b, 1'b0);
      checks++;
      if (img[7:0] !== b) begin
         errors++;
         $display("FAIL missing_pixel0 got=%h exp=%h", img[7:0], b);
      end
      send_frame(N - 1, N - 2, 1);
      checks++;
      if (img_diffs(img) !== 0 || start !== 1'b1) begin
         errors++;
         $display("FAIL missing_next_frame diffs=%0d start=%b exp=0,1", img_diffs(img), start);
      end
      repeat (3) @(negedge clk);
      dg = 4'($urandom);
      done = 1'b1;
      pred = dg;
      wait_resp(5, c);
      checks++;
      if (r_valid !== 1'b1 || r_data !== {4'h0, dg}) begin
         errors++;
         $display("FAIL missing_result r_valid=%b r_data=%h exp=1,%h", r_valid, r_data, {4'h0, dg});
      end
      handshake();
   endtask

   task automatic test_stale_done();
      int early = 0;
      send_frame(N - 1, -1, 0);
      done = 1'b1;
      pred = 4'd2;
      send_byte(8'($urandom), 1'b1);
      for (int i = 0; i < 6; i++) begin
         if (r_valid !== 1'b0) early++;
         @(negedge clk);
      end
      if (r_valid !== 1'b0) early++;
      done = 1'b0;
      @(negedge clk);
      if (r_valid !== 1'b0) early++;
      done = 1'b1;
      pred = 4'd9;
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL stale_capture early_cycles=%0d exp=0", early);
      end
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1 || r_data !== 8'h09) begin
         errors++;
         $display("FAIL stale_result r_valid=%b r_data=%h exp=1,09", r_valid, r_data);
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      int c;
      logic [3:0] dg;
      for (int f = 0; f < 3; f++) begin
         send_frame(N, N - 1, 1);
         checks++;
         if (img_diffs(img) !== 0 || start !== 1'b1) begin
            errors++;
            $display("FAIL b2b_img[%0d] diffs=%0d start=%b exp=0,1", f, img_diffs(img), start);
         end
         repeat ($urandom_range(40, 2)) @(negedge clk);
         dg = 4'($urandom);
         done = 1'b1;
         pred = dg;
         wait_resp(5, c);
         checks++;
         if (r_valid !== 1'b1 || r_data !== {4'h0, dg} || c !== 1) begin
            errors++;
            $display("FAIL b2b_result[%0d] r_valid=%b r_data=%h lat=%0d exp=1,%h,1",
                     f, r_valid, r_data, c, {4'h0, dg});
         end
         repeat ($urandom_range(3, 0)) @(negedge clk);
         handshake();
         checks++;
         if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reenter[%0d] s_ready=%b exp=1", f, s_ready);
         end
      end
   endtask

   task automatic test_timeout_bp();
      int cnt = 0;
      int unstable = 0;
      logic [7:0] b;
      en_t = 1'b1;
      done = 1'b0;
      @(negedge clk);
      send_frame(N, N - 1, 0);
      checks++;
      if (t_start !== 1'b1) begin
         errors++;
         $display("FAIL tmo_start got=%b exp=1", t_start);
      end
      while (t_r_valid !== 1'b1 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      checks++;
      if (cnt !== 64 || t_r_valid !== 1'b1 || t_r_data !== 8'hE0) begin
         errors++;
         $display("FAIL tmo_fire cycles=%0d r_valid=%b r_data=%h exp=64,1,e0",
                  cnt, t_r_valid, t_r_data);
      end
      r_ready = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (t_r_valid !== 1'b1 || t_r_data !== 8'hE0 || t_busy !== 1'b1) unstable++;
      end
      checks++;
      if (unstable !== 0) begin
         errors++;
         $display("FAIL tmo_backpressure unstable=%0d exp=0", unstable);
      end
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
      checks++;
      if (t_s_ready !== 1'b1 || t_busy !== 1'b0 || t_r_valid !== 1'b0 || t_ferr !== 1'b0) begin
         errors++;
         $display("FAIL tmo_reenter s_ready=%b busy=%b r_valid=%b ferr=%b exp=1,0,0,0",
                  t_s_ready, t_busy, t_r_valid, t_ferr);
      end
      b = 8'($urandom);
      send_byte(b, 1'b0);
      checks++;
      if (t_img[7:0] !== b) begin
         errors++;
         $display("FAIL tmo_new_frame got=%h exp=%h", t_img[7:0], b);
      end
      en_t = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      rst     = 1'b0;
      en_t    = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
      done    = 1'b0;
      pred    = 4'h0;
      r_ready = 1'b0;
      model_reset();
      test_reset();
      test_nominal();
      test_early_last();
      test_missing_last();
      test_stale_done();
      test_back_to_back();
      test_timeout_bp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
